// File: rtl/key_filter.sv
// Two-flop synchroniser plus per-key debounce FSM for active-low push-buttons.
// Produces one-cycle press flags, debounced held levels and a combined flag.
module key_filter #(
  parameter int KEY_NUM = 4,
  parameter int DEB_CNT = 1000000,
  parameter int CNT_W   = 20
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] flag_key,
  output logic [KEY_NUM-1:0] key_state,
  output logic               flag_any
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILTER_DN = 2'd1,
    DOWN      = 2'd2,
    FILTER_UP = 2'd3
  } key_fsm_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  logic [KEY_NUM-1:0] sync_1;
  logic [KEY_NUM-1:0] sync_2;
  logic [KEY_NUM-1:0] flag_nxt;

  // Synchroniser resets to released so a held key cannot flag straight out of reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_1 <= '1;
      sync_2 <= '1;
    end else begin
      sync_1 <= key_in;
      sync_2 <= sync_1;
    end
  end

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    key_fsm_t         state;
    logic [CNT_W-1:0] cnt;
    logic             flag_r;
    logic             level_r;

    // The press is accepted on the edge that completes the low-filter count.
    assign flag_nxt[g] = (state == FILTER_DN) && !sync_2[g] && (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        state   <= IDLE;
        cnt     <= '0;
        flag_r  <= 1'b0;
        level_r <= 1'b0;
      end else begin
        flag_r <= flag_nxt[g];
        case (state)
          IDLE: begin
            cnt <= '0;
            if (!sync_2[g]) state <= FILTER_DN;
          end
          FILTER_DN: begin
            if (sync_2[g]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= DOWN;
              cnt     <= '0;
              level_r <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DOWN: begin
            cnt     <= '0;
            level_r <= 1'b1;
            if (sync_2[g]) state <= FILTER_UP;
          end
          FILTER_UP: begin
            if (!sync_2[g]) begin
              state <= DOWN;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= IDLE;
              cnt     <= '0;
              level_r <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign flag_key[g]  = flag_r;
    assign key_state[g] = level_r;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) flag_any <= 1'b0;
    else       flag_any <= |flag_nxt;
  end

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter with DEB_CNT=4: scenario tasks drive keys, expected flag
// pulses (cycle + pattern) are queued and matched by a negedge monitor.
module tb_key_filter;

  localparam int KEY_NUM = 4;
  localparam int DEB     = 4;
  localparam int CNT_W   = 3;
  localparam int LAT     = DEB + 3;
  localparam int W       = 32 + KEY_NUM;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [KEY_NUM-1:0] key_in = '1;
  logic [KEY_NUM-1:0] flag_key;
  logic [KEY_NUM-1:0] key_state;
  logic               flag_any;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [KEY_NUM-1:0] prev_flag = '0;

  key_filter #(
    .KEY_NUM(KEY_NUM),
    .DEB_CNT(DEB),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK      (clk),
    .RSTn     (rst_n),
    .key_in   (key_in),
    .flag_key (flag_key),
    .key_state(key_state),
    .flag_any (flag_any)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor: cyc equals the index of the last rising edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    checks++;
    if (flag_any !== (|flag_key)) begin
      failures++;
      $display("FAIL flag_any cyc=%0d got=%b exp=%b", cyc, flag_any, |flag_key);
    end
    checks++;
    if ((flag_key & prev_flag) !== '0) begin
      failures++;
      $display("FAIL flag_width cyc=%0d got=%b prev=%b exp=no repeat", cyc, flag_key, prev_flag);
    end
    prev_flag = flag_key;
    if (exp_q.size() != 0 && int'(exp_q[0][W-1:KEY_NUM]) <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (int'(e[W-1:KEY_NUM]) != cyc || flag_key !== e[KEY_NUM-1:0]) begin
        failures++;
        $display("FAIL flag_key cyc=%0d got=%b exp=%b at cyc=%0d",
                 cyc, flag_key, e[KEY_NUM-1:0], int'(e[W-1:KEY_NUM]));
      end
    end else if (flag_key !== '0) begin
      checks++;
      failures++;
      $display("FAIL flag_unexpected cyc=%0d got=%b exp=0000", cyc, flag_key);
    end
  end

  // driver tasks
  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic settle();
    int n;
    key_in = '1;
    n = 0;
    while ((exp_q.size() != 0 || n < 12) && n < 80) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    key_in = '1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (flag_key !== '0) begin failures++; $display("FAIL reset_flag_key got=%b exp=0000", flag_key); end
    checks++;
    if (key_state !== '0) begin failures++; $display("FAIL reset_key_state got=%b exp=0000", key_state); end
    checks++;
    if (flag_any !== 1'b0) begin failures++; $display("FAIL reset_flag_any got=%b exp=0", flag_any); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (key_state !== '0) begin failures++; $display("FAIL post_reset_key_state got=%b exp=0000", key_state); end
  endtask

  task automatic test_clean_press();
    int c;
    int r;
    @(negedge clk);
    c = cyc;
    key_in[0] = 1'b0;
    exp_q.push_back({32'(c + LAT), 4'b0001});
    wait_to(c + LAT - 1);
    checks++;
    if (key_state[0] !== 1'b0) begin failures++; $display("FAIL clean_state_early got=%b exp=0", key_state[0]); end
    wait_to(c + LAT);
    checks++;
    if (key_state !== 4'b0001) begin failures++; $display("FAIL clean_state_rise got=%b exp=0001", key_state); end
    checks++;
    if (flag_any !== 1'b1) begin failures++; $display("FAIL clean_flag_any got=%b exp=1", flag_any); end
    wait_to(c + 20);
    r = cyc;
    key_in[0] = 1'b1;
    wait_to(r + LAT - 1);
    checks++;
    if (key_state[0] !== 1'b1) begin failures++; $display("FAIL clean_release_early got=%b exp=1", key_state[0]); end
    wait_to(r + LAT);
    checks++;
    if (key_state[0] !== 1'b0) begin failures++; $display("FAIL clean_release got=%b exp=0", key_state[0]); end
    settle();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL clean_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    int f;
    pat = 6'b001001;
    @(negedge clk);
    for (int i = 5; i >= 0; i--) begin
      key_in[1] = pat[i];
      @(negedge clk);
    end
    key_in[1] = 1'b0;
    f = cyc;
    checks++;
    if (key_state[1] !== 1'b0) begin failures++; $display("FAIL bounce_state_during got=%b exp=0", key_state[1]); end
    exp_q.push_back({32'(f + LAT), 4'b0010});
    wait_to(f + LAT);
    checks++;
    if (key_state[1] !== 1'b1) begin failures++; $display("FAIL bounce_state_rise got=%b exp=1", key_state[1]); end
    wait_to(f + 15);
    settle();
    checks++;
    if (key_state[1] !== 1'b0) begin failures++; $display("FAIL bounce_release got=%b exp=0", key_state[1]); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL bounce_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_long_hold();
    int c;
    int r;
    @(negedge clk);
    c = cyc;
    key_in[2] = 1'b0;
    exp_q.push_back({32'(c + LAT), 4'b0100});
    wait_to(c + 100);
    r = cyc;
    key_in[2] = 1'b1;
    wait_to(r + 2);
    key_in[2] = 1'b0;
    wait_to(r + 3);
    key_in[2] = 1'b1;
    wait_to(r + 6);
    checks++;
    if (key_state[2] !== 1'b1) begin failures++; $display("FAIL hold_glitch_state got=%b exp=1", key_state[2]); end
    wait_to(r + 9);
    checks++;
    if (key_state[2] !== 1'b1) begin failures++; $display("FAIL hold_before_fall got=%b exp=1", key_state[2]); end
    wait_to(r + 10);
    checks++;
    if (key_state[2] !== 1'b0) begin failures++; $display("FAIL hold_fall got=%b exp=0", key_state[2]); end
    settle();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL hold_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_simultaneous();
    int c;
    @(negedge clk);
    c = cyc;
    key_in = 4'b0110;
    exp_q.push_back({32'(c + LAT), 4'b1001});
    wait_to(c + LAT);
    checks++;
    if (key_state !== 4'b1001) begin failures++; $display("FAIL simul_state got=%b exp=1001", key_state); end
    checks++;
    if (flag_any !== 1'b1) begin failures++; $display("FAIL simul_flag_any got=%b exp=1", flag_any); end
    wait_to(c + LAT + 1);
    checks++;
    if (flag_any !== 1'b0) begin failures++; $display("FAIL simul_flag_any_off got=%b exp=0", flag_any); end
    wait_to(c + 15);
    settle();
    checks++;
    if (key_state !== 4'b0000) begin failures++; $display("FAIL simul_release got=%b exp=0000", key_state); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL simul_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int c;
    int d;
    int e;
    @(negedge clk);
    c = cyc;
    key_in[0] = 1'b0;
    wait_to(c + 4);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({flag_key, key_state, flag_any} !== '0) begin
      failures++;
      $display("FAIL rst_filter_outputs got=%b_%b_%b exp=0", flag_key, key_state, flag_any);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d = cyc;
    exp_q.push_back({32'(d + LAT), 4'b0001});
    wait_to(d + LAT);
    checks++;
    if (key_state[0] !== 1'b1) begin failures++; $display("FAIL rst_repress_state got=%b exp=1", key_state[0]); end
    wait_to(d + LAT + 2);
    rst_n = 1'b0;
    #1;
    checks++;
    if (key_state !== '0) begin failures++; $display("FAIL rst_down_state got=%b exp=0000", key_state); end
    checks++;
    if (flag_key !== '0) begin failures++; $display("FAIL rst_down_flag got=%b exp=0000", flag_key); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e = cyc;
    exp_q.push_back({32'(e + LAT), 4'b0001});
    wait_to(e + LAT - 1);
    checks++;
    if (key_state[0] !== 1'b0) begin failures++; $display("FAIL rst_held_early got=%b exp=0", key_state[0]); end
    wait_to(e + LAT);
    checks++;
    if (key_state[0] !== 1'b1) begin failures++; $display("FAIL rst_held_state got=%b exp=1", key_state[0]); end
    settle();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rst_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  // Random press/release runs on key 1; the model accepts a level after DEB+1 equal samples.
  task automatic test_back_to_back();
    logic lvl;
    logic raw;
    int run;
    int len;
    int c;
    logic lq[$];
    lvl = 1'b0;
    raw = 1'b1;
    run = 0;
    @(negedge clk);
    for (int n = 0; n < 26; n++) begin
      raw = ~raw;
      len = (n >= 22) ? 10 : $urandom_range(2, 8);
      for (int j = 0; j < len; j++) begin
        c = cyc;
        if (lq.size() == 3) begin
          checks++;
          if (key_state[1] !== lq[0]) begin
            failures++;
            $display("FAIL b2b_state cyc=%0d got=%b exp=%b", cyc, key_state[1], lq[0]);
          end
          void'(lq.pop_front());
        end
        key_in[1] = raw;
        if ((raw == 1'b0) != lvl) run++;
        else run = 0;
        if (run == DEB + 1) begin
          lvl = ~lvl;
          run = 0;
          if (lvl) exp_q.push_back({32'(c + 3), 4'b0010});
        end
        lq.push_back(lvl);
        @(negedge clk);
      end
    end
    settle();
    checks++;
    if (key_state[1] !== lvl) begin failures++; $display("FAIL b2b_final got=%b exp=%b", key_state[1], lvl); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout cyc=%0d exp=finish before limit", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_filter.md
Name: key_filter

Overview:
- Input-side counterpart to the seven-segment display path.
- Synchronises and debounces the raw active-low push-buttons.
- Emits the one-cycle flag_key pulses that the display control logic and vending FSM consume, plus debounced key levels.
- Sits between the board key pins and the control logic, in the same CLK domain as the display driver.

Parameters:
- KEY_NUM, 4, number of independent keys.
- DEB_CNT, 1000000, stable-sample cycles required to accept a press or release (20 ms at 50 MHz); legal range 2..2^CNT_W.
- CNT_W, 20, width of each per-key debounce counter.

Ports:
- CLK  input  1  system clock.
- RSTn  input  1  reset; asynchronous, active-low.
- key_in  input  KEY_NUM  raw key pins, asynchronous to CLK; 0 = pressed.
- flag_key  output  KEY_NUM  one-CLK-cycle pulse per accepted press, bit i for key i.
- key_state  output  KEY_NUM  debounced level, 1 = held down.
- flag_any  output  1  registered OR of the flag_key bits; high in the same cycle as any flag_key bit.

Behaviour:
- Reset (RSTn low, asynchronous):
  - Both synchroniser stages reset to 1 (released).
  - All key FSMs go to IDLE and all counters to 0.
  - flag_key, key_state and flag_any reset to 0.
  - Release of reset is synchronous to CLK.
- Synchroniser: each key_in bit passes through 2 flip-flops; the FSM sees only the second stage (sync_i).
- Per-key FSM: four states, fully independent per key, no priority or interaction between keys.
  - IDLE: cnt = 0. If sync_i = 0, go to FILTER_DN with cnt = 0.
  - FILTER_DN:
    - If sync_i = 1, go to IDLE (bounce rejected, no flag).
    - Else if cnt = DEB_CNT-1, go to DOWN and register flag_key[i] = 1 for exactly one cycle.
    - Else cnt += 1.
  - DOWN: key_state[i] = 1. If sync_i = 1, go to FILTER_UP with cnt = 0.
  - FILTER_UP:
    - If sync_i = 0, go to DOWN (release bounce rejected; no new flag).
    - Else if cnt = DEB_CNT-1, go to IDLE and set key_state[i] = 0.
    - Else cnt += 1.
- Outputs are registered:
  - key_state[i] = 1 in states DOWN and FILTER_UP.
  - flag_key is never high for two consecutive cycles on the same bit.
- Press latency: let edge E0 be the first rising CLK edge that samples key_in[i] = 0. If the key is held low, flag_key[i] is high in the cycle following edge E0 + DEB_CNT + 2. key_state[i] rises on that same edge.
- Release latency: symmetric; key_state[i] falls DEB_CNT + 2 edges after the first edge that samples key_in[i] = 1.
- Holding a key gives exactly one flag. No auto-repeat. A new flag requires a full debounced release followed by a new press.
- Simultaneous events:
  - Multiple keys completing their filter on the same edge produce simultaneous flag_key bits.
  - flag_any is high once for that cycle.
- Counter never wraps: it saturates logically via the DEB_CNT-1 compare and resets on every state entry.
- Reset mid-filter or mid-hold aborts with no pulse. A key still held when reset releases must complete a full FILTER_DN before it flags.

Test Plan:
- Clean press (DEB_CNT=4): key_in[0] 1→0, held 20 cycles → flag_key = 4'b0001 exactly one cycle, asserted DEB_CNT+2 = 6 edges after E0; key_state[0] = 1 from that edge; flag_any pulses with it.
- Bounce (DEB_CNT=4): key_in[1] low 2 cycles, high 1, low 2, high 1, then stays low → no flag during the bounce; one flag_key[1] pulse 6 edges after the final stable-low sample.
- Long hold and release (DEB_CNT=4): key_in[2] low 100 cycles, then high with a 1-cycle low glitch after 2 cycles → single flag; key_state[2] stays 1 through the glitch and falls 6 edges after the last 1-after-glitch sample; no second flag.
- Simultaneous (DEB_CNT=4): key_in[0] and key_in[3] fall on the same cycle → flag_key = 4'b1001 for one cycle; flag_any = 1 for one cycle; key_state = 4'b1001.
- Reset mid-operation (DEB_CNT=4): RSTn asserted mid-FILTER_DN and again during DOWN → outputs 0 immediately (asynchronous), no flag. After RSTn rises with the key still low → flag 6 edges after the first low sample post-reset.
- Default parameters: DEB_CNT=1000000 press → flag at edge E0 + 1000002; pulse width exactly 1 cycle.
